// File: rtl/cp_bit_feeder_if.sv
// Word-wide payload handshake into the bit feeder.
// The master drives data/valid; the feeder returns ready.
interface cp_bit_feeder_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/cp_bit_feeder.sv
// Word FIFO plus shifter that serialises payload into the cyclic-prefix
// stage's data_in/start pair, inserting filler slots at the end of each frame.
module cp_bit_feeder #(
    parameter int FRAME_LEN   = 100,
    parameter int PAYLOAD_LEN = 90,
    parameter int WORD_W      = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    cp_bit_feeder_if.slave                in_if,
    output logic                          out_bit,
    output logic                          out_start,
    output logic [6:0]                    out_slot,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   stall_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [LW-1:0]     level;
    logic              full;
    logic              empty;

    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     bits_left;
    logic [6:0]        slot;
    logic [6:0]        slot_nxt;

    logic payload;
    logic last_slot;
    logic emit;
    logic stall;
    logic adv;
    logic push;
    logic load;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LW'(FIFO_DEPTH));
    assign empty = (level == '0);

    assign in_if.in_ready = !full;
    assign fifo_level     = level;

    assign payload   = (slot < 7'(PAYLOAD_LEN));
    assign last_slot = (slot == 7'(FRAME_LEN - 1));
    assign slot_nxt  = last_slot ? 7'd0 : slot + 7'd1;

    assign emit  = enable && payload && (bits_left != '0);
    assign stall = enable && payload && (bits_left == '0);
    assign adv   = enable && !stall;

    assign push = in_if.in_valid && !full;
    // Refill on the same edge the last bit leaves so words stream seamlessly.
    assign load = !empty &&
                  ((bits_left == '0) ||
                   ((bits_left == BW'(1)) && emit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_if.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bits_left <= '0;
        end else if (load) begin
            shreg     <= mem[rd_ptr[AW-1:0]];
            bits_left <= BW'(WORD_W);
        end else if (emit) begin
            shreg     <= {shreg[WORD_W-2:0], 1'b0};
            bits_left <= bits_left - BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot       <= '0;
            out_bit    <= 1'b0;
            out_start  <= 1'b0;
            out_slot   <= '0;
            frame_done <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            out_start  <= adv;
            frame_done <= adv && last_slot;
            if (adv) begin
                out_slot <= slot;
                slot     <= slot_nxt;
                out_bit  <= emit ? shreg[WORD_W-1] : 1'b0;
            end
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/cp_bit_feeder.md
Name: cp_bit_feeder

Overview:
- Upstream neighbour of the transmitter's cyclic-prefix stage: converts a word-wide payload stream into the bit-serial data_in/start pair that stage consumes.
- Enforces the stage's frame layout of FRAME_LEN slots per frame: slots 0..PAYLOAD_LEN-1 carry payload bits, MSB first; the remaining slots are filler.
- Absorbs upstream burstiness with a small word FIFO.
- On payload underrun, deasserts start to freeze the downstream frame counter, so frame alignment is never lost.

Parameters:
- FRAME_LEN, 100, slots per frame (downstream counter modulus)
- PAYLOAD_LEN, 90, payload slots per frame; must be < FRAME_LEN
- WORD_W, 8, input word width
- FIFO_DEPTH, 4, word FIFO entries; power of 2, >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  synchronous run enable
- in_data  in  WORD_W  payload word
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word
- out_bit  out  1  serial bit; drives downstream data_in
- out_start  out  1  slot-advance strobe; drives downstream start
- out_slot  out  7  slot index of the bit currently presented
- frame_done  out  1  one-cycle pulse, coincident with the out_start of slot FRAME_LEN-1
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words held in FIFO, excluding the shifter
- stall_cnt  out  16  saturating count of underrun cycles

Behaviour:
- Clock and reset: clk rising edge; rst_n asynchronous, active-low.
- Reset values:
  - out_bit=0, out_start=0, out_slot=0, frame_done=0
  - FIFO empty, fifo_level=0, in_ready=1
  - shifter empty (bits_left=0), internal slot=0, stall_cnt=0
- Reset mid-operation discards all buffered words and partial frames. The next frame begins at slot 0.
- Input handshake:
  - A word is accepted on a clk edge where in_valid && in_ready.
  - in_ready = !FIFO full, combinational from registered state.
  - When full, no write occurs even if a read happens in the same cycle.
- Shifter: WORD_W-bit register with bits_left counter (0..WORD_W).
  - Loads the FIFO head when FIFO is non-empty and either bits_left==0, or bits_left==1 and a payload bit is emitted this cycle (seamless back-to-back).
  - Loading is independent of enable, so the shifter prefetches. Total capacity is FIFO_DEPTH+1 words.
  - FIFO read and write in the same cycle are legal; fifo_level is unchanged.
- Slot logic, evaluated each edge; outputs are registered:
  - enable=0: out_start<=0, frame_done<=0. Slot, out_bit and stall_cnt hold.
  - enable=1, slot<PAYLOAD_LEN, bits_left>0:
    - out_start<=1, out_bit<=shifter MSB, out_slot<=slot
    - shift left, bits_left-1, slot+1
  - enable=1, slot<PAYLOAD_LEN, bits_left==0 (underrun):
    - out_start<=0; out_bit and slot hold
    - stall_cnt+1, saturating at 0xFFFF
  - enable=1, slot>=PAYLOAD_LEN (filler): out_start<=1, out_bit<=0, out_slot<=slot, slot+1. Never stalls.
  - Slot wraps FRAME_LEN-1 -> 0.
  - frame_done<=1 exactly when out_start<=1 with out_slot<=FRAME_LEN-1.
- Word boundaries do not align to frames: leftover bits of a word carry across the filler gap into the next frame's slot 0.
- Latency, empty block with enable=1:
  - word accepted at edge t
  - loaded into shifter at edge t+1
  - its MSB appears on out_bit with out_start=1 after edge t+2
- Invariant: the count of out_start pulses modulo FRAME_LEN equals the downstream stage's counter after the same reset.

Test Plan:
- Reset: assert rst_n=0 mid-stream at slot 45 -> all outputs 0 immediately, in_ready=1. After release, the first pulse has out_slot=0.
- Continuous flow: enable=1, stream bytes 0x00..0x0B back-to-back.
  - First out_start after 2 cycles.
  - Slots 0..89 carry bytes 0..10 MSB-first, then bits 7,6 of 0x0B.
  - Slots 90..99 give out_bit=0, out_start=1; frame_done pulses at slot 99.
  - Frame 2 slot 0 carries bit 5 of 0x0B.
- Underrun: send only 0xFF -> slots 0..7 give 1s, then out_start=0 and stall_cnt increments each cycle. Sending 0x80 resumes at slot 8 with bit 1, with no slot skipped.
- Backpressure: enable=0, present 6 words.
  - 5 accepted (4 FIFO + shifter); in_ready=0 from the 6th; fifo_level=4.
  - Raising enable drains them; in_ready returns 1 one cycle after the first FIFO read.
- Enable pause in filler: drop enable for 3 cycles at slot 95 -> out_start=0 for 3 cycles, then slots 95..99 resume. stall_cnt is unchanged.
- Stall saturation: hold underrun for 70000 cycles -> stall_cnt=0xFFFF and stays.
